application_selector_irq_ctrl: RTL



---
 rtl/application_selector_irq_pkg.sv | 35 +++
 rtl/application_selector_irq_prio_enc.sv | 22 ++
 rtl/application_selector_irq_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/application_selector_irq_pkg.sv
// Shared definitions for the application selector interrupt aggregator:
// register offsets, HIGHEST register layout and the priority-encoder result type.
package application_selector_irq_pkg;

  // Register offsets on the 16-bit slave port
  localparam logic [2:0] IRQ_PENDING  = 3'd0;
  localparam logic [2:0] IRQ_ENABLE   = 3'd1;
  localparam logic [2:0] IRQ_EDGE_SEL = 3'd2;
  localparam logic [2:0] IRQ_ACTIVE   = 3'd3;
  localparam logic [2:0] IRQ_HIGHEST  = 3'd4;
  localparam logic [2:0] IRQ_SWTRIG   = 3'd5;

  // HIGHEST register layout
  localparam int unsigned HIGHEST_VALID_BIT = 15;
  localparam int unsigned HIGHEST_ID_W      = 4;

  // Largest source count that still fits the 4-bit ID and 16-bit registers
  localparam int unsigned NUM_IRQ_MAX = 15;

  // Result of the fixed-priority encoder
  typedef struct packed {
    logic                    valid;
    logic [HIGHEST_ID_W-1:0] id;
  } prio_t;

  // Place a priority result into the 16-bit HIGHEST register image
  function automatic logic [15:0] highest_reg(prio_t p);
    logic [15:0] r;
    r                    = '0;
    r[HIGHEST_VALID_BIT] = p.valid;
    r[HIGHEST_ID_W-1:0]  = p.id;
    return r;
  endfunction

endpackage

// File: rtl/application_selector_irq_prio_enc.sv
// Fixed-priority encoder: lowest-index set bit of the active vector wins.
module application_selector_irq_prio_enc
  import application_selector_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] active,
  output prio_t              highest
);

  // Scan from the top down so the lowest active index is the last one written
  always_comb begin
    highest.valid = |active;
    highest.id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        highest.id = i[HIGHEST_ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/application_selector_irq_ctrl.sv
// Memory-mapped interrupt aggregator. Synchronises up to NUM_IRQ sources, latches them
// as edge- or level-captured pending bits, masks them with ENABLE and drives a single
// registered irq_out. Read data is registered with one cycle of latency.
module application_selector_irq_ctrl
  import application_selector_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq_out
);

  localparam int unsigned PadW = 16 - NUM_IRQ;

  logic [NUM_IRQ-1:0] irq_q, irq_qq;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
  logic [15:0]        readdata_d;
  logic               irq_out_d;

  logic               wr;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] swset;
  logic [NUM_IRQ-1:0] active;
  prio_t              highest;
  logic               unused_wdata;

  assign wr           = chipselect & ~write_n;
  // Bits at and above NUM_IRQ are dropped on write
  assign wdata        = writedata[NUM_IRQ-1:0];
  assign unused_wdata = ^writedata[15:NUM_IRQ];

  assign rise   = irq_q & ~irq_qq;
  assign active = pending_q & enable_q;

  application_selector_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .active  (active),
    .highest (highest)
  );

  // Decode W1C / software-trigger strobes
  always_comb begin
    clr   = '0;
    swset = '0;
    if (wr && (address == IRQ_PENDING)) begin
      clr = wdata;
    end
    if (wr && (address == IRQ_SWTRIG)) begin
      swset = wdata;
    end
  end

  // Pending next state: edge bits set-wins over clear, level bits track the synchronised
  // input. The mode used is the one registered before this edge, so an EDGE_SEL write
  // affects pending behaviour from the following cycle.
  always_comb begin
    pending_d = (edge_sel_q & ((pending_q & ~clr) | rise | swset))
              | (~edge_sel_q & irq_q);
  end

  // Control register writes
  always_comb begin
    enable_d   = enable_q;
    edge_sel_d = edge_sel_q;
    if (wr && (address == IRQ_ENABLE)) begin
      enable_d = wdata;
    end
    if (wr && (address == IRQ_EDGE_SEL)) begin
      edge_sel_d = wdata;
    end
  end

  // Read mux; reserved and write-only offsets read as zero
  always_comb begin
    readdata_d = '0;
    case (address)
      IRQ_PENDING:  readdata_d = {{PadW{1'b0}}, pending_q};
      IRQ_ENABLE:   readdata_d = {{PadW{1'b0}}, enable_q};
      IRQ_EDGE_SEL: readdata_d = {{PadW{1'b0}}, edge_sel_q};
      IRQ_ACTIVE:   readdata_d = {{PadW{1'b0}}, active};
      IRQ_HIGHEST:  readdata_d = highest_reg(highest);
      default:      readdata_d = '0;
    endcase
  end

  // Interrupt output is computed from registered pending/enable only
  always_comb begin
    irq_out_d = |active;
  end

  // State registers with synchronous reset; a write in a reset cycle is discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q      <= '0;
      irq_qq     <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edge_sel_q <= '0;
      readdata   <= '0;
      irq_out    <= 1'b0;
    end else begin
      irq_q      <= irq_in;
      irq_qq     <= irq_q;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_sel_q <= edge_sel_d;
      readdata   <= readdata_d;
      irq_out    <= irq_out_d;
    end
  end

endmodule
